// File: rtl/gsim_shreg_ctrl_if.sv
// Handshake bundle between the GSIM shift-register sequencer and its neighbours
// (I/O FSM load/drain port, shift-register control, update PE handshake).
interface gsim_shreg_ctrl_if #(
    parameter int ITER_W = 5
);
    logic              start;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        sh_ctrl;
    logic              sh_ien;
    logic              pe_start;
    logic              pe_done;
    logic [ITER_W-1:0] iter_cnt;
    logic              out_valid;
    logic              out_ready;
    logic              done;

    modport master (
        input  start, in_valid, pe_done, out_ready,
        output busy, in_ready, sh_ctrl, sh_ien, pe_start, iter_cnt, out_valid, done
    );

    modport slave (
        output start, in_valid, pe_done, out_ready,
        input  busy, in_ready, sh_ctrl, sh_ien, pe_start, iter_cnt, out_valid, done
    );
endinterface

// File: rtl/gsim_shreg_ctrl.sv
// Sequencer for the GSIM unknown shift register: load, Gauss-Seidel sweeps, drain.
// Optional early termination on convergence: define GSIM_CTRL_EARLY_STOP_EN.
module gsim_shreg_ctrl #(
    parameter int N_UNK    = 16,
    parameter int ITER_NUM = 16,
    parameter int ITER_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef GSIM_CTRL_EARLY_STOP_EN
    input  logic               converged,
`endif
    gsim_shreg_ctrl_if.master  bus
);

    localparam int UNK_W = (N_UNK > 1) ? $clog2(N_UNK) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;

    // Codes 01 (SH4) and 10 (SH5) are reserved for neighbour realignment.
    localparam logic [1:0] SH_SH1  = 2'b00;
    localparam logic [1:0] SH_HOLD = 2'b11;

    localparam logic [UNK_W-1:0]  UNK_LAST  = UNK_W'(N_UNK - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITER_NUM - 1);

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [UNK_W-1:0]  unk_cnt_r;
    logic [UNK_W-1:0]  unk_cnt_nxt_s;
    logic [ITER_W-1:0] iter_cnt_r;
    logic [ITER_W-1:0] iter_cnt_nxt_s;
    logic [1:0]        sh_ctrl_s;
    logic              sh_ien_s;
    logic              stop_s;

    logic              busy_r;
    logic              in_ready_r;
    logic              pe_start_r;
    logic              out_valid_r;
    logic              done_r;

`ifdef GSIM_CTRL_EARLY_STOP_EN
    assign stop_s = converged;
`else
    assign stop_s = 1'b0;
`endif

    // Next-state, counter update and same-cycle shift-register control
    always_comb begin
        state_nxt_s    = state_r;
        unk_cnt_nxt_s  = unk_cnt_r;
        iter_cnt_nxt_s = iter_cnt_r;
        sh_ctrl_s      = SH_HOLD;
        sh_ien_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    iter_cnt_nxt_s = {ITER_W{1'b0}};
                    unk_cnt_nxt_s  = {UNK_W{1'b0}};
                    state_nxt_s    = ST_LOAD;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.in_valid) begin
                    sh_ctrl_s = SH_SH1;
                    sh_ien_s  = 1'b1;
                    if (unk_cnt_r == UNK_LAST) begin
                        unk_cnt_nxt_s = {UNK_W{1'b0}};
                        state_nxt_s   = ST_ISSUE;
                    end else begin
                        unk_cnt_nxt_s = unk_cnt_r + UNK_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.pe_done) begin
                    // Updated head value re-enters at the tail as the rest shift forward
                    sh_ctrl_s = SH_SH1;
                    sh_ien_s  = 1'b1;
                    if (unk_cnt_r == UNK_LAST) begin
                        unk_cnt_nxt_s  = {UNK_W{1'b0}};
                        iter_cnt_nxt_s = iter_cnt_r + ITER_W'(1);
                        if ((iter_cnt_r == ITER_LAST) || stop_s) begin
                            state_nxt_s = ST_DRAIN;
                        end else begin
                            state_nxt_s = ST_ISSUE;
                        end
                    end else begin
                        unk_cnt_nxt_s = unk_cnt_r + UNK_W'(1);
                        state_nxt_s   = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (bus.out_ready) begin
                    // Rotate with input disabled so a full drain restores the order
                    sh_ctrl_s = SH_SH1;
                    sh_ien_s  = 1'b0;
                    if (unk_cnt_r == UNK_LAST) begin
                        unk_cnt_nxt_s = {UNK_W{1'b0}};
                        state_nxt_s   = ST_FIN;
                    end else begin
                        unk_cnt_nxt_s = unk_cnt_r + UNK_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_FIN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                unk_cnt_nxt_s  = {UNK_W{1'b0}};
                iter_cnt_nxt_s = {ITER_W{1'b0}};
            end
        endcase
    end

    // State, counters and registered status outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            unk_cnt_r   <= {UNK_W{1'b0}};
            iter_cnt_r  <= {ITER_W{1'b0}};
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            pe_start_r  <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            unk_cnt_r   <= unk_cnt_nxt_s;
            iter_cnt_r  <= iter_cnt_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            in_ready_r  <= (state_nxt_s == ST_LOAD);
            pe_start_r  <= (state_nxt_s == ST_ISSUE);
            out_valid_r <= (state_nxt_s == ST_DRAIN);
            done_r      <= (state_nxt_s == ST_FIN);
        end
    end

    assign bus.busy      = busy_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.pe_start  = pe_start_r;
    assign bus.out_valid = out_valid_r;
    assign bus.done      = done_r;
    assign bus.iter_cnt  = iter_cnt_r;
    assign bus.sh_ctrl   = sh_ctrl_s;
    assign bus.sh_ien    = sh_ien_s;

endmodule

// File: tb/tb_gsim_shreg_ctrl.sv
// Directed bench for gsim_shreg_ctrl with a behavioural 16-entry shift-register model.
// Build with GSIM_CTRL_EARLY_STOP_EN defined to exercise convergence stop.
module tb_gsim_shreg_ctrl;

    localparam int N   = 16;
    localparam int ITW = 5;
`ifdef GSIM_CTRL_EARLY_STOP_EN
    localparam int ITER = 16;
`else
    localparam int ITER = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
`ifdef GSIM_CTRL_EARLY_STOP_EN
    logic converged;
`endif

    always #5 clk = ~clk;

    gsim_shreg_ctrl_if #(.ITER_W(ITW)) bif ();

    gsim_shreg_ctrl #(
        .N_UNK    (N),
        .ITER_NUM (ITER),
        .ITER_W   (ITW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef GSIM_CTRL_EARLY_STOP_EN
        .converged (converged),
`endif
        .bus       (bif)
    );

    int total = 0;
    int bad   = 0;
    int sr [N];
    int wdata;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bif.start     = 1'b0;
        bif.in_valid  = 1'b0;
        bif.pe_done   = 1'b0;
        bif.out_ready = 1'b0;
`ifdef GSIM_CTRL_EARLY_STOP_EN
        converged     = 1'b0;
`endif
    endtask

    // Apply one shift-register move as the real register would at the coming edge
    task automatic model_shift();
        int head;
        if (bif.sh_ctrl == 2'b00) begin
            head = sr[0];
            for (int i = 0; i < N - 1; i++) sr[i] = sr[i + 1];
            sr[N - 1] = bif.sh_ien ? wdata : head;
        end
    endtask

    task automatic run_seq(input bit stall_load, input bit toggle_rdy,
                           input int conv_sweep, input int abort_at);
        int  ncyc, beats, drops, n_ien_load, n_pe_start, n_given, n_done, n_acc;
        int  hold_bad, ord_bad, exp_s, exp_cyc;
        int  cyc_last_load, cyc_first_issue, cyc_last_pedone, cyc_first_ov;
        bit  prev_ps, ph, poked, fin;
        ncyc = 0; beats = 0; drops = 0; n_ien_load = 0; n_pe_start = 0;
        n_given = 0; n_done = 0; n_acc = 0; hold_bad = 0; ord_bad = 0;
        cyc_last_load = 0; cyc_first_issue = -1; cyc_last_pedone = 0; cyc_first_ov = -1;
        prev_ps = 1'b0; ph = 1'b1; poked = 1'b0; fin = 1'b0;
        exp_s = ITER;
        if (conv_sweep > 0 && conv_sweep < ITER) exp_s = conv_sweep;
        exp_cyc = 1 + N + (stall_load ? 2 : 0) + 2 * N * exp_s + N + (toggle_rdy ? N - 1 : 0) + 1;

        while (!fin && ncyc < 3000) begin
            clear_inputs();
            wdata = 0;
            bif.start = (ncyc == 0);
            if (bif.out_valid && !poked) begin
                bif.start = 1'b1;
                poked     = 1'b1;
            end
            if (bif.in_ready) begin
                if (stall_load && beats == 8 && drops < 2) begin
                    drops++;
                end else begin
                    bif.in_valid = 1'b1;
                    wdata        = beats + 1;
                end
            end
            if (prev_ps) begin
                if (abort_at > 0 && n_given == abort_at) begin
                    check_val("pre_rst_iter", bif.iter_cnt, 1);
                    rst_n = 1'b0;
                    #1;
                    check_val("rst_busy", bif.busy, 0);
                    check_val("rst_iter", bif.iter_cnt, 0);
                    check_val("rst_shctrl", bif.sh_ctrl, 3);
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    check_val("rst_idle_busy", bif.busy, 0);
                    check_val("rst_idle_pestart", bif.pe_start, 0);
                    for (int i = 0; i < N; i++) sr[i] = 0;
                    return;
                end
                bif.pe_done = 1'b1;
                wdata       = sr[0] + 100;
`ifdef GSIM_CTRL_EARLY_STOP_EN
                converged   = (conv_sweep > 0) && (n_given == conv_sweep * N - 1);
`endif
            end
            if (bif.out_valid) begin
                bif.out_ready = toggle_rdy ? ph : 1'b1;
                ph = !ph;
            end
            #3;
            ncyc++;
            if (bif.in_ready && bif.sh_ien) begin
                n_ien_load++;
                cyc_last_load = ncyc;
            end
            if (bif.in_ready && bif.in_valid) beats++;
            if (bif.pe_start) begin
                n_pe_start++;
                if (cyc_first_issue < 0) cyc_first_issue = ncyc;
            end
            if (bif.pe_done) begin
                n_given++;
                cyc_last_pedone = ncyc;
            end
            if (bif.out_valid) begin
                if (cyc_first_ov < 0) cyc_first_ov = ncyc;
                if (bif.out_ready) begin
                    check_val("drain_data", sr[0], n_acc + 1 + 100 * exp_s);
                    n_acc++;
                end else if (bif.sh_ctrl !== 2'b11) begin
                    hold_bad++;
                end
            end
            if (bif.done) begin
                n_done++;
                fin = 1'b1;
            end
            prev_ps = bif.pe_start;
            model_shift();
            @(posedge clk); #1;
        end

        clear_inputs();
        #3;
        check_val("post_busy", bif.busy, 0);
        check_val("post_done", bif.done, 0);
        check_val("post_in_ready", bif.in_ready, 0);
        @(posedge clk); #1;

        for (int i = 0; i < N; i++) if (sr[i] != i + 1 + 100 * exp_s) ord_bad++;
        check_val("timeout", fin, 1);
        check_val("load_ien", n_ien_load, N);
        check_val("load_to_issue", cyc_first_issue - cyc_last_load, 1);
        check_val("pe_starts", n_pe_start, N * exp_s);
        check_val("iter_cnt", bif.iter_cnt, exp_s);
        check_val("pedone_to_ov", cyc_first_ov - cyc_last_pedone, 1);
        check_val("drain_beats", n_acc, N);
        check_val("stall_hold", hold_bad, 0);
        check_val("done_pulses", n_done, 1);
        check_val("cycles", ncyc, exp_cyc);
        check_val("order", ord_bad, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) sr[i] = 0;
        wdata = 0;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_sh_ctrl", bif.sh_ctrl, 3);
        check_val("rst_busy0", bif.busy, 0);
        check_val("rst_in_ready", bif.in_ready, 0);
        check_val("rst_sh_ien", bif.sh_ien, 0);
        check_val("rst_pe_start", bif.pe_start, 0);
        check_val("rst_out_valid", bif.out_valid, 0);
        check_val("rst_done", bif.done, 0);
        check_val("rst_iter0", bif.iter_cnt, 0);
        rst_n = 1'b1;

        // Idle: stray in_valid / pe_done must not move the register
        for (int c = 0; c < 5; c++) begin
            bif.in_valid = (c % 2 == 0);
            bif.pe_done  = (c % 2 == 1);
            #3;
            check_val("idle_hold", bif.sh_ctrl, 3);
            check_val("idle_busy", bif.busy, 0);
            @(posedge clk); #1;
        end
        clear_inputs();
        @(posedge clk); #1;

`ifdef GSIM_CTRL_EARLY_STOP_EN
        run_seq(1'b0, 1'b0, 3, 0);
`endif
        run_seq(1'b0, 1'b0, 0, 0);
        run_seq(1'b1, 1'b1, 0, 0);
        run_seq(1'b0, 1'b0, 0, N + 7);
        @(posedge clk); #1;
        run_seq(1'b0, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
